axi_lite_req_arbiter: RTL
=========================

// Module: axi_lite_req_arbiter
// PURPOSE
//  Shares one AXI-Lite master port (the upstream port of the address-decoding bus) between two requesters.
//  Performs round-robin arbitration and buffers each transaction.
//  Only one transaction (write or read) is outstanding at a time.
//  Sits between the two traffic sources and the bus slave port s0.
// PARAMETERS
//  DATA_WIDTH  32  data bus width
//  ADDR_WIDTH  8   address width
//  RESP_WIDTH  3   bresp/rresp width, matches bus
//  STRB_WIDTH  5   wstrb width, matches bus (DATA_WIDTH/8+1)
// PORTS (requester ports packed: requester i at [i*W +: W], i=0..1)
//  axi_aclk      in   1              sole clock
//  axi_areset    in   1              synchronous, active-high reset
//  s_axi_awaddr  in   2*ADDR_WIDTH   requester write addresses
//  s_axi_awvalid/s_axi_awready  in/out  2   write-address handshake per requester
//  s_axi_wdata   in   2*DATA_WIDTH   requester write data
//  s_axi_wstrb   in   2*STRB_WIDTH   requester write strobes
//  s_axi_wvalid/s_axi_wready    in/out  2   write-data handshake
//  s_axi_bresp   out  2*RESP_WIDTH   write response per requester
//  s_axi_bvalid/s_axi_bready    out/in  2   write-response handshake
//  s_axi_araddr  in   2*ADDR_WIDTH   requester read addresses
//  s_axi_arvalid/s_axi_arready  in/out  2   read-address handshake
//  s_axi_rdata   out  2*DATA_WIDTH   read data
//  s_axi_rresp   out  2*RESP_WIDTH   read response
//  s_axi_rvalid/s_axi_rready    out/in  2   read-data handshake
//  m_axi_awaddr/awvalid/awready   out/out/in  ADDR_WIDTH/1/1  shared write address
//  m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_WIDTH/STRB_WIDTH/1/1  shared write data
//  m_axi_bresp/bvalid/bready   in/in/out  RESP_WIDTH/1/1  shared write response
//  m_axi_araddr/arvalid/arready  out/out/in  ADDR_WIDTH/1/1  shared read address
//  m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_WIDTH/RESP_WIDTH/1/1  shared read data
//  grant_id      out  1              requester currently owning the port
//  busy          out  1              1 in any state other than IDLE
// BEHAVIOUR
//  - All outputs registered. In reset, every valid, ready, busy and grant_id is 0.
//    Data/resp outputs are 0. State is IDLE. rr_last=1, so requester 0 wins first.
//  - Request i: write if awvalid[i]&wvalid[i]; read if arvalid[i]. Write beats read within the same requester.
//  - IDLE: if requester !rr_last requests, grant it, else grant rr_last if requesting.
//    On grant, set grant_id and rr_last <= grant, and assert s_awready+s_wready (or s_arready) of the granted requester only.
//    Go to W_ACC / R_ACC. No request -> stay.
//  - W_ACC: capture awaddr/wdata/wstrb of grant (valid held per AXI); drop readies.
//    Set m_awvalid=m_wvalid=1 -> W_ADDR.
//  - W_ADDR: clear m_awvalid on awvalid&awready, clear m_wvalid on wvalid&wready, each independently.
//    Same-cycle or either order is allowed. When both are done, set m_bready=1 -> W_BWAIT.
//  - W_BWAIT: on m_bvalid, capture bresp and drop m_bready.
//    Drive s_bvalid[grant]=1 and s_bresp[grant] -> W_RESP.
//  - W_RESP: hold s_bvalid until s_bready[grant] -> clear it, IDLE.
//  - R_ACC: capture araddr; drop arready; m_arvalid=1 -> R_ADDR.
//  - R_ADDR: on m_arready, clear m_arvalid and set m_rready=1 -> R_WAIT.
//  - R_WAIT: on m_rvalid, capture rdata/rresp and drop m_rready.
//    Drive s_rvalid[grant] -> R_RESP. R_RESP: hold until s_rready[grant] -> IDLE.
//  - Non-granted requester: all readies and valids stay 0; its payload is ignored until its grant.
//  - Minimum write latency: request seen to m_awvalid = 2 cycles. No new grant while busy.
//  - Reset asserted in any state aborts the transaction: outputs return to reset values next cycle.
//    The downstream handshake is abandoned.
// TESTING
//  1. Req0 write awaddr=0x04, wdata=0xDEADBEEF, wstrb=0x0F; slave bresp=0.
//     -> m_awaddr=0x04, m_wdata=0xDEADBEEF; s_bvalid=2'b01, bresp=0; s_bvalid[1] never set.
//  2. Both request writes in same cycle after reset (addrs 0x00, 0x10).
//     -> grant_id 0 then 1; m_awaddr 0x00 then 0x10; rr_last=1 at end.
//  3. Req1 read araddr=0x18; slave rvalid 3 cycles after arready with rdata=0x12345678.
//     -> s_rdata[63:32]=0x12345678, s_rvalid=2'b10 held until s_rready[1].
//  4. Req0 asserts write and read together -> write completes first, read granted next IDLE.
//  5. m_awready on cycle 1, m_wready on cycle 4 -> m_bready rises only after the wready handshake.
//     Hold s_bready low 5 cycles -> s_bvalid held, busy=1, no new grant.
//  6. Reset in W_BWAIT -> next cycle all valids/readies=0, busy=0.
//     A post-reset request from req1 alone is granted.

Source files
------------

// File: rtl/axi_lite_req_arbiter.sv
// rtl/axi_lite_req_arbiter.sv - two-requester round-robin AXI-Lite arbiter, one transaction in flight
module axi_lite_req_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int STRB_WIDTH = 5
) (
  input  logic                    axi_aclk,
  input  logic                    axi_areset,
  input  logic [2*ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [1:0]              s_axi_awvalid,
  output logic [1:0]              s_axi_awready,
  input  logic [2*DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [2*STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic [1:0]              s_axi_wvalid,
  output logic [1:0]              s_axi_wready,
  output logic [2*RESP_WIDTH-1:0] s_axi_bresp,
  output logic [1:0]              s_axi_bvalid,
  input  logic [1:0]              s_axi_bready,
  input  logic [2*ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [1:0]              s_axi_arvalid,
  output logic [1:0]              s_axi_arready,
  output logic [2*DATA_WIDTH-1:0] s_axi_rdata,
  output logic [2*RESP_WIDTH-1:0] s_axi_rresp,
  output logic [1:0]              s_axi_rvalid,
  input  logic [1:0]              s_axi_rready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [RESP_WIDTH-1:0]   m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [RESP_WIDTH-1:0]   m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    grant_id,
  output logic                    busy
);

  typedef enum logic [3:0] {
    IDLE, W_ACC, W_ADDR, W_BWAIT, W_RESP, R_ACC, R_ADDR, R_WAIT, R_RESP
  } state_t;

  state_t     state, next_state;
  logic       rr_last;
  logic [1:0] req_w, req_r, req;
  logic       pick, pick_write;
  logic [1:0] pick_oh, grant_oh;
  logic       aw_done, w_done;

  assign req_w    = s_axi_awvalid & s_axi_wvalid;
  assign req_r    = s_axi_arvalid;
  assign req      = req_w | req_r;
  assign pick_oh  = pick ? 2'b10 : 2'b01;
  assign grant_oh = grant_id ? 2'b10 : 2'b01;
  // A channel counts as done once its valid is already low or is being accepted this cycle.
  assign aw_done  = !m_axi_awvalid || m_axi_awready;
  assign w_done   = !m_axi_wvalid || m_axi_wready;

  always_comb begin
    pick       = rr_last;
    pick_write = 1'b0;
    next_state = state;
    if (req[~rr_last]) pick = ~rr_last;
    pick_write = req_w[pick];
    case (state)
      IDLE:    if (|req) next_state = pick_write ? W_ACC : R_ACC;
      W_ACC:   next_state = W_ADDR;
      W_ADDR:  if (aw_done && w_done) next_state = W_BWAIT;
      W_BWAIT: if (m_axi_bvalid) next_state = W_RESP;
      W_RESP:  if (s_axi_bready[grant_id]) next_state = IDLE;
      R_ACC:   next_state = R_ADDR;
      R_ADDR:  if (m_axi_arready) next_state = R_WAIT;
      R_WAIT:  if (m_axi_rvalid) next_state = R_RESP;
      R_RESP:  if (s_axi_rready[grant_id]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state         <= IDLE;
      rr_last       <= 1'b1;
      grant_id      <= 1'b0;
      busy          <= 1'b0;
      s_axi_awready <= '0;
      s_axi_wready  <= '0;
      s_axi_arready <= '0;
      s_axi_bvalid  <= '0;
      s_axi_bresp   <= '0;
      s_axi_rvalid  <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      case (state)
        IDLE: if (|req) begin
          grant_id      <= pick;
          rr_last       <= pick;
          s_axi_awready <= pick_write ? pick_oh : 2'b00;
          s_axi_wready  <= pick_write ? pick_oh : 2'b00;
          s_axi_arready <= pick_write ? 2'b00 : pick_oh;
        end
        W_ACC: begin
          m_axi_awaddr  <= s_axi_awaddr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
          m_axi_wdata   <= s_axi_wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
          m_axi_wstrb   <= s_axi_wstrb[grant_id*STRB_WIDTH +: STRB_WIDTH];
          s_axi_awready <= 2'b00;
          s_axi_wready  <= 2'b00;
          m_axi_awvalid <= 1'b1;
          m_axi_wvalid  <= 1'b1;
        end
        W_ADDR: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready) m_axi_wvalid <= 1'b0;
          if (aw_done && w_done) m_axi_bready <= 1'b1;
        end
        W_BWAIT: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          s_axi_bvalid <= grant_oh;
          s_axi_bresp[grant_id*RESP_WIDTH +: RESP_WIDTH] <= m_axi_bresp;
        end
        W_RESP: if (s_axi_bready[grant_id]) s_axi_bvalid <= 2'b00;
        R_ACC: begin
          m_axi_araddr  <= s_axi_araddr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
          s_axi_arready <= 2'b00;
          m_axi_arvalid <= 1'b1;
        end
        R_ADDR: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b1;
        end
        R_WAIT: if (m_axi_rvalid) begin
          m_axi_rready <= 1'b0;
          s_axi_rvalid <= grant_oh;
          s_axi_rdata[grant_id*DATA_WIDTH +: DATA_WIDTH] <= m_axi_rdata;
          s_axi_rresp[grant_id*RESP_WIDTH +: RESP_WIDTH] <= m_axi_rresp;
        end
        R_RESP: if (s_axi_rready[grant_id]) s_axi_rvalid <= 2'b00;
        default: ;
      endcase
    end
  end

endmodule
